next_pc_unit: RTL and testbench

Registered program-counter generator for the fetch stage.
- Selects the next PC by fixed priority among:
  - redirect (exception/flush)
  - stall hold
  - absolute jump decoded from the fetched instruction
  - return from a small return-address stack (RAS)
  - taken branch
  - sequential increment
- Replaces the former combinational PC mux; feeds the instruction-memory address each cycle.

---
 rtl/next_pc_pkg.sv | 16 +
 rtl/next_pc_unit_if.sv | 35 +++
 rtl/ras_stack.sv | 62 ++++++
 rtl/next_pc_unit.sv | 102 ++++++++++
 tb/tb_next_pc_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/next_pc_pkg.sv
// Shared types and defaults for the fetch-stage next-PC generator.
package next_pc_pkg;

    typedef enum logic [2:0] {
        SRC_REDIRECT,
        SRC_HOLD,
        SRC_JUMP,
        SRC_RET,
        SRC_BRANCH,
        SRC_SEQ
    } next_src_e;

    localparam logic [4:0]  JUMP_OPCODE_DEF = 5'b11101;
    localparam int unsigned INSTR_BYTES_DEF = 4;

endpackage

// File: rtl/next_pc_unit_if.sv
// Control and status bundle between the fetch pipeline and the next-PC unit.
interface next_pc_unit_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
);

    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic              stall_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              instr_valid_i;
    logic [31:0]       instr_i;
    logic              link_i;
    logic              ret_i;
    logic              branch_taken_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic [ADDR_W-1:0] pc_o;
    logic              pc_valid_o;
    logic [CntW-1:0]   ras_count_o;
    logic              ret_miss_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i, instr_valid_i, instr_i, link_i, ret_i,
               branch_taken_i, branch_target_i,
        input  pc_o, pc_valid_o, ras_count_o, ret_miss_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, instr_valid_i, instr_i, link_i, ret_i,
               branch_taken_i, branch_target_i,
        output pc_o, pc_valid_o, ras_count_o, ret_miss_o
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           push_data_i,
    output logic [WIDTH-1:0]           top_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    // Points at the next free slot; the top entry sits one below it.
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PtrW-1:0]  top_idx;

    assign top_idx = ptr_q - PtrW'(1);

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push_i) begin
            mem_d[ptr_q] = push_data_i;
            ptr_d        = ptr_q + PtrW'(1);
            if (count_q != CntW'(DEPTH)) begin
                count_d = count_q + CntW'(1);
            end
        end else if (pop_i && (count_q != '0)) begin
            ptr_d   = top_idx;
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign top_data_o = mem_q[top_idx];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/next_pc_unit.sv
// Registered fetch PC: fixed-priority select among redirect, stall, jump, return, branch, sequential.
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       INSTR_BYTES  = INSTR_BYTES_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [4:0]        JUMP_OPCODE  = JUMP_OPCODE_DEF,
    parameter int unsigned       TGT_W        = 26,
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input logic           clk,
    input logic           rst_n,
    next_pc_unit_if.slave bus
);

    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] Step      = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              ret_miss_q, ret_miss_d;

    next_src_e         src;
    logic              jump_hit;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] pc_seq;
    logic              ras_push, ras_pop, ras_empty;
    logic [ADDR_W-1:0] ras_top;

    // Instruction bits between the opcode and the target field carry no meaning here.
    logic unused_instr;
    assign unused_instr = ^bus.instr_i[26:TGT_W];

    assign jump_hit = bus.instr_valid_i && (bus.instr_i[31:27] == JUMP_OPCODE);
    assign jump_tgt = ADDR_W'(bus.instr_i[TGT_W-1:0]);
    assign pc_seq   = pc_q + Step;

    always_comb begin
        src        = SRC_SEQ;
        ret_miss_d = 1'b0;
        if (bus.redirect_i) begin
            src = SRC_REDIRECT;
        end else if (bus.stall_i) begin
            src = SRC_HOLD;
        end else if (jump_hit) begin
            src = SRC_JUMP;
        end else if (bus.ret_i && !ras_empty) begin
            src = SRC_RET;
        end else begin
            ret_miss_d = bus.ret_i;
            src        = bus.branch_taken_i ? SRC_BRANCH : SRC_SEQ;
        end
    end

    assign ras_push = (src == SRC_JUMP) && bus.link_i;
    assign ras_pop  = (src == SRC_RET);

    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        case (src)
            SRC_REDIRECT: pc_d = bus.redirect_pc_i & AlignMask;
            SRC_HOLD:     pc_d = pc_q;
            SRC_JUMP:     pc_d = jump_tgt & AlignMask;
            SRC_RET:      pc_d = ras_top & AlignMask;
            SRC_BRANCH:   pc_d = bus.branch_target_i & AlignMask;
            default:      pc_d = pc_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            ret_miss_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            ret_miss_q <= ret_miss_d;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_seq),
        .top_data_o  (ras_top),
        .count_o     (bus.ras_count_o),
        .empty_o     (ras_empty)
    );

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = pc_valid_q;
    assign bus.ret_miss_o = ret_miss_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit.
module tb_next_pc_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    next_pc_unit_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();

    next_pc_unit #(
        .ADDR_W       (32),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (32'h0000_0000),
        .JUMP_OPCODE  (5'b11101),
        .TGT_W        (26),
        .RAS_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_i         = 1'b0;
        bus.redirect_i      = 1'b0;
        bus.redirect_pc_i   = '0;
        bus.instr_valid_i   = 1'b0;
        bus.instr_i         = '0;
        bus.link_i          = 1'b0;
        bus.ret_i           = 1'b0;
        bus.branch_taken_i  = 1'b0;
        bus.branch_target_i = '0;
    endtask

    task automatic jump_link(input logic [31:0] instr);
        idle();
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = instr;
        bus.link_i        = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (bus.pc_o !== 32'h0) begin
            tests_failed++; $display("FAIL reset_pc got=%h exp=0", bus.pc_o);
        end
        tests_run++;
        if (bus.pc_valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid got=%b exp=0", bus.pc_valid_o);
        end
        tests_run++;
        if (bus.ras_count_o !== 3'd0 || bus.ret_miss_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ras count=%0d miss=%b exp=0/0", bus.ras_count_o, bus.ret_miss_o);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = 32'(i * 4);
            tests_run++;
            if (bus.pc_o !== exp || bus.pc_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL seq%0d pc=%h valid=%b exp=%h/1", i, bus.pc_o, bus.pc_valid_o, exp);
            end
        end
    endtask

    task automatic test_jump_vs_branch();
        idle();
        bus.instr_valid_i   = 1'b1;
        bus.instr_i         = 32'hE800_0100;
        bus.branch_taken_i  = 1'b1;
        bus.branch_target_i = 32'h200;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h100) begin
            tests_failed++; $display("FAIL jump_over_branch got=%h exp=100", bus.pc_o);
        end
        bus.instr_valid_i   = 1'b0;
        bus.branch_target_i = 32'h203;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h200) begin
            tests_failed++; $display("FAIL branch_align got=%h exp=200", bus.pc_o);
        end
        idle();
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = 32'hF000_0100;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h204) begin
            tests_failed++; $display("FAIL non_jump_opcode got=%h exp=204", bus.pc_o);
        end
        idle();
        bus.link_i = 1'b1;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h208 || bus.ras_count_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL link_no_jump pc=%h count=%0d exp=208/0", bus.pc_o, bus.ras_count_o);
        end
        idle();
    endtask

    task automatic test_stall_redirect();
        idle();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h40) begin
            tests_failed++; $display("FAIL redirect40 got=%h exp=40", bus.pc_o);
        end
        idle();
        bus.stall_i = 1'b1;
        bus.ret_i   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (bus.pc_o !== 32'h40 || bus.ret_miss_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall%0d pc=%h miss=%b exp=40/0", i, bus.pc_o, bus.ret_miss_o);
            end
        end
        bus.ret_i         = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h80;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h80) begin
            tests_failed++; $display("FAIL redirect_over_stall got=%h exp=80", bus.pc_o);
        end
        bus.redirect_pc_i = 32'h8B;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h88) begin
            tests_failed++; $display("FAIL redirect_align got=%h exp=88", bus.pc_o);
        end
        idle();
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h8C) begin
            tests_failed++; $display("FAIL post_redirect_seq got=%h exp=8c", bus.pc_o);
        end
    endtask

    task automatic test_call_return();
        idle();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h10;
        tick();
        jump_link(32'hE800_0100);
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h100 || bus.ras_count_o !== 3'd1) begin
            tests_failed++;
            $display("FAIL call pc=%h count=%0d exp=100/1", bus.pc_o, bus.ras_count_o);
        end
        idle();
        tick();
        bus.ret_i = 1'b1;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h14 || bus.ras_count_o !== 3'd0 || bus.ret_miss_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL return pc=%h count=%0d miss=%b exp=14/0/0",
                     bus.pc_o, bus.ras_count_o, bus.ret_miss_o);
        end
        idle();
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
        for (int i = 0; i < 5; i++) begin
            idle();
            bus.redirect_i    = 1'b1;
            bus.redirect_pc_i = 32'(i * 32'h100);
            tick();
            jump_link(32'hE800_1000);
            tick();
            exp_cnt = (i >= 3) ? 3'd4 : 3'(i + 1);
            tests_run++;
            if (bus.pc_o !== 32'h1000 || bus.ras_count_o !== exp_cnt) begin
                tests_failed++;
                $display("FAIL push%0d pc=%h count=%0d exp=1000/%0d",
                         i, bus.pc_o, bus.ras_count_o, exp_cnt);
            end
        end
        idle();
        bus.ret_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_pc  = 32'((4 - k) * 32'h100 + 4);
            exp_cnt = 3'(3 - k);
            tests_run++;
            if (bus.pc_o !== exp_pc || bus.ras_count_o !== exp_cnt || bus.ret_miss_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL pop%0d pc=%h count=%0d miss=%b exp=%h/%0d/0",
                         k, bus.pc_o, bus.ras_count_o, bus.ret_miss_o, exp_pc, exp_cnt);
            end
        end
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h108 || bus.ret_miss_o !== 1'b1 || bus.ras_count_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL underflow pc=%h miss=%b count=%0d exp=108/1/0",
                     bus.pc_o, bus.ret_miss_o, bus.ras_count_o);
        end
        bus.ret_i = 1'b0;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h10C || bus.ret_miss_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL miss_pulse pc=%h miss=%b exp=10c/0", bus.pc_o, bus.ret_miss_o);
        end
        bus.ret_i           = 1'b1;
        bus.branch_taken_i  = 1'b1;
        bus.branch_target_i = 32'h500;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h500 || bus.ret_miss_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL miss_branch pc=%h miss=%b exp=500/1", bus.pc_o, bus.ret_miss_o);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h20;
        tick();
        jump_link(32'hE800_0300);
        tick();
        idle();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h30;
        tick();
        jump_link(32'hE800_0300);
        tick();
        tests_run++;
        if (bus.ras_count_o !== 3'd2) begin
            tests_failed++; $display("FAIL pre_reset_count got=%0d exp=2", bus.ras_count_o);
        end
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h80;
        bus.ret_i         = 1'b1;
        rst_n             = 1'b0;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h0 || bus.ras_count_o !== 3'd0 || bus.ret_miss_o !== 1'b0 ||
            bus.pc_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset pc=%h count=%0d miss=%b valid=%b exp=0/0/0/0",
                     bus.pc_o, bus.ras_count_o, bus.ret_miss_o, bus.pc_valid_o);
        end
        idle();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h4 || bus.pc_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset pc=%h valid=%b exp=4/1", bus.pc_o, bus.pc_valid_o);
        end
        bus.ret_i = 1'b1;
        tick();
        tests_run++;
        if (bus.pc_o !== 32'h8 || bus.ret_miss_o !== 1'b1 || bus.ras_count_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL ras_cleared pc=%h miss=%b count=%0d exp=8/1/0",
                     bus.pc_o, bus.ret_miss_o, bus.ras_count_o);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_jump_vs_branch();
        test_stall_redirect();
        test_call_return();
        test_ras_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
